// File: rtl/ie_fwd_ctrl.sv
// ie_fwd_ctrl: execute-stage operand forwarding, load-use stalls and data-memory freezes.
// Define IE_FWD_WB_EN to forward WB-stage results (select 11) instead of stalling on them.
module ie_fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_uses_pc,
    input  logic              id_uses_imm,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              dmem_busy,
    output logic [1:0]        IE_mux1_SEL,
    output logic [1:0]        IE_mux2_SEL,
    output logic              stall_if_id,
    output logic              bubble_ie,
    output logic              freeze,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } tag_t;

    typedef enum logic [1:0] {
        RUN,
        HAZ,
        MEM_WAIT
    } state_t;

    localparam logic [1:0] SEL_REG    = 2'b00;
    localparam logic [1:0] SEL_DIRECT = 2'b01;
    localparam logic [1:0] SEL_IM     = 2'b10;
    localparam logic [1:0] SEL_WB     = 2'b11;

    tag_t       ie_tag, im_tag, wb_tag, id_tag;
    state_t     state, state_next;
    logic [2:0] res1, res2;
    logic       hazard;
    logic [1:0] sel1_next, sel2_next;

    function automatic logic tag_match(input tag_t t, input logic [REG_AW-1:0] src,
                                       input logic used);
        return used && (src != '0) && t.valid && t.we && (t.rd == src);
    endfunction

    // Returns {stall, select}; the youngest matching stage decides.
    function automatic logic [2:0] resolve(input tag_t ie, input tag_t im, input tag_t wb,
                                           input logic [REG_AW-1:0] src, input logic used);
        logic [2:0] r;
        r = {1'b0, SEL_REG};
        if (tag_match(ie, src, used)) begin
            r = ie.load ? {1'b1, SEL_REG} : {1'b0, SEL_IM};
        end else if (tag_match(im, src, used)) begin
            r = im.load ? {1'b1, SEL_REG} : {1'b0, SEL_IM};
        end else if (tag_match(wb, src, used)) begin
`ifdef IE_FWD_WB_EN
            r = {1'b0, SEL_WB};
`else
            r = {1'b1, SEL_REG};
`endif
        end
        return r;
    endfunction

    always_comb begin
        res1      = resolve(ie_tag, im_tag, wb_tag, id_rs1_addr, id_valid && id_rs1_used);
        res2      = resolve(ie_tag, im_tag, wb_tag, id_rs2_addr, id_valid && id_rs2_used);
        hazard    = res1[2] | res2[2];
        sel1_next = (id_valid && id_uses_pc)  ? SEL_DIRECT : res1[1:0];
        sel2_next = (id_valid && id_uses_imm) ? SEL_DIRECT : res2[1:0];

        id_tag       = '0;
        id_tag.valid = id_valid;
        id_tag.rd    = id_rd_addr;
        id_tag.we    = id_rd_we;
        id_tag.load  = id_is_load;
    end

    // A busy data memory always wins over an operand hazard.
    always_comb begin
        state_next  = state;
        stall_if_id = 1'b0;
        bubble_ie   = 1'b0;
        freeze      = 1'b0;
        case (state)
            MEM_WAIT: begin
                if (dmem_busy) begin
                    freeze      = 1'b1;
                    stall_if_id = 1'b1;
                end else if (hazard) begin
                    stall_if_id = 1'b1;
                    bubble_ie   = 1'b1;
                    state_next  = HAZ;
                end else begin
                    state_next  = RUN;
                end
            end
            default: begin
                if (dmem_busy) begin
                    freeze      = 1'b1;
                    stall_if_id = 1'b1;
                    state_next  = MEM_WAIT;
                end else if (hazard) begin
                    stall_if_id = 1'b1;
                    bubble_ie   = 1'b1;
                    state_next  = HAZ;
                end else begin
                    state_next  = RUN;
                end
            end
        endcase
        if (!rst_n) begin
            stall_if_id = 1'b0;
            bubble_ie   = 1'b0;
            freeze      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            ie_tag       <= '0;
            im_tag       <= '0;
            wb_tag       <= '0;
            IE_mux1_SEL  <= SEL_REG;
            IE_mux2_SEL  <= SEL_REG;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            if ((stall_if_id || freeze) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (!freeze) begin
                wb_tag <= im_tag;
                im_tag <= ie_tag;
                ie_tag <= (bubble_ie || !id_valid) ? '0 : id_tag;
                if (bubble_ie) begin
                    IE_mux1_SEL <= SEL_REG;
                    IE_mux2_SEL <= SEL_REG;
                end else begin
                    IE_mux1_SEL <= sel1_next;
                    IE_mux2_SEL <= sel2_next;
                end
            end
        end
    end

endmodule
